ssd_scan_ctrl: RTL and testbench

- Time-multiplexed scan controller for a multi-digit seven-segment display.
- Shares one registered BCD-to-segment decoder (1-cycle latency, 4-bit in, 7-bit out) across DIGITS common-anode digits.
- Holds a tear-free display buffer loaded through a ready/valid handshake.
- Drives the decoder input and the active-low digit anodes; applies ghost-suppression guard time and optional leading-zero blanking.

---
 rtl/ssd_scan_ctrl.sv | 158 +++++++++++++++
 tb/tb_ssd_scan_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/ssd_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller: tear-free display buffer,
// guard-time ghost suppression and optional leading-zero blanking.

module ssd_scan_ctrl_chk #(
    parameter int DIGITS = 4
) (
    input logic              CLK,
    input logic              RST,
    input logic [DIGITS-1:0] an,
    input logic              frame_done
);

    // At most one anode may be driven low at any time.
    a_an_onehot0: assert property (@(posedge CLK) disable iff (RST) $onehot0(~an));

    // The end-of-frame strobe lasts a single cycle.
    a_fd_pulse: assert property (@(posedge CLK) disable iff (RST) frame_done |=> !frame_done);

endmodule

module ssd_scan_ctrl #(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int GUARD       = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic                  blank_lz,
    output logic                  ready,
    output logic [3:0]            digit_code,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_done
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int DW = $clog2(REFRESH_DIV);

    localparam logic [IW-1:0] LAST_IDX  = IW'(DIGITS - 1);
    localparam logic [DW-1:0] LAST_CNT  = DW'(REFRESH_DIV - 1);
    localparam logic [DW-1:0] GUARD_CNT = DW'(GUARD);

    // Digit i (i >= 1) is blanked when it and every more significant nibble are zero.
    function automatic logic [DIGITS-1:0] lz_mask(input logic [4*DIGITS-1:0] digits);
        logic zero_above;
        zero_above = 1'b1;
        lz_mask    = {DIGITS{1'b0}};
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_above = zero_above & (digits[4*i +: 4] == 4'd0);
            lz_mask[i] = zero_above;
        end
    endfunction

    logic [DW-1:0]         div_cnt_q, div_cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [4*DIGITS-1:0]   shadow_q, shadow_d;
    logic [4*DIGITS-1:0]   pending_q, pending_d;
    logic                  ready_q, ready_d;
    logic [3:0]            digit_code_q, digit_code_d;
    logic [DIGITS-1:0]     an_q, an_d;
    logic                  frame_done_q, frame_done_d;

    logic                  tc_s;
    logic                  boundary_s;
    logic                  accept_s;
    logic [DIGITS-1:0]     blank_s;
    logic [DIGITS-1:0]     sel_s;

    // Divider, slot index, buffer handshake and registered display outputs.
    always_comb begin
        tc_s         = (div_cnt_q == LAST_CNT);
        boundary_s   = tc_s && (idx_q == LAST_IDX);
        accept_s     = load && ready_q;

        div_cnt_d    = div_cnt_q;
        idx_d        = idx_q;
        pending_d    = pending_q;
        shadow_d     = shadow_q;
        ready_d      = ready_q;
        an_d         = {DIGITS{1'b1}};
        sel_s        = {DIGITS{1'b0}};

        if (tc_s) begin
            div_cnt_d = {DW{1'b0}};
            if (idx_q == LAST_IDX) begin
                idx_d = {IW{1'b0}};
            end else begin
                idx_d = idx_q + {{(IW-1){1'b0}}, 1'b1};
            end
        end else begin
            div_cnt_d = div_cnt_q + {{(DW-1){1'b0}}, 1'b1};
            idx_d     = idx_q;
        end

        // A load accepted on a boundary edge means ready was high, so no transfer competes with it.
        if (accept_s) begin
            pending_d = value;
            ready_d   = 1'b0;
        end else if (boundary_s && !ready_q) begin
            shadow_d  = pending_q;
            ready_d   = 1'b1;
        end else begin
            pending_d = pending_q;
            shadow_d  = shadow_q;
            ready_d   = ready_q;
        end

        blank_s      = lz_mask(shadow_d);
        digit_code_d = shadow_d[{idx_d, 2'b00} +: 4];
        frame_done_d = boundary_s;

        if ((div_cnt_d >= GUARD_CNT) && !(blank_lz && blank_s[idx_d])) begin
            sel_s = {{(DIGITS-1){1'b0}}, 1'b1} << idx_d;
            an_d  = ~sel_s;
        end else begin
            an_d  = {DIGITS{1'b1}};
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            div_cnt_q    <= {DW{1'b0}};
            idx_q        <= {IW{1'b0}};
            shadow_q     <= {(4*DIGITS){1'b0}};
            pending_q    <= {(4*DIGITS){1'b0}};
            ready_q      <= 1'b1;
            digit_code_q <= 4'd0;
            an_q         <= {DIGITS{1'b1}};
            frame_done_q <= 1'b0;
        end else begin
            div_cnt_q    <= div_cnt_d;
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            pending_q    <= pending_d;
            ready_q      <= ready_d;
            digit_code_q <= digit_code_d;
            an_q         <= an_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign ready      = ready_q;
    assign digit_code = digit_code_q;
    assign an         = an_q;
    assign frame_done = frame_done_q;

    ssd_scan_ctrl_chk #(
        .DIGITS     (DIGITS)
    ) u_chk (
        .CLK        (CLK),
        .RST        (RST),
        .an         (an_q),
        .frame_done (frame_done_q)
    );

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Scoreboard bench for ssd_scan_ctrl: a frame-level reference model predicts every
// cycle's outputs, and an independent monitor compares them against the DUT.

module tb_ssd_scan_ctrl;

    localparam int DIGITS = 4;
    localparam int RDIV   = 8;
    localparam int GRD    = 2;
    localparam int FRAME  = DIGITS * RDIV;

    logic        CLK;
    logic        RST;
    logic        load;
    logic [15:0] value;
    logic        blank_lz;
    logic        ready;
    logic [3:0]  digit_code;
    logic [3:0]  an;
    logic        frame_done;

    ssd_scan_ctrl #(
        .DIGITS      (DIGITS),
        .REFRESH_DIV (RDIV),
        .GUARD       (GRD)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .load       (load),
        .value      (value),
        .blank_lz   (blank_lz),
        .ready      (ready),
        .digit_code (digit_code),
        .an         (an),
        .frame_done (frame_done)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct packed {
        logic       rdy;
        logic [3:0] code;
        logic [3:0] an;
        logic       fd;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   cycle_no    = 0;

    // Reference model: position within the frame, displayed buffer, pending buffer.
    int          m_t;
    logic [15:0] m_shadow;
    logic [15:0] m_pending;
    bit          m_ready;

    task automatic model_step(input bit rst, input bit ld, input logic [15:0] val, input bit blz);
        exp_t        e;
        bit          boundary;
        bit          accept;
        int          slot;
        int          cyc;
        logic [15:0] upper;
        logic [3:0]  onehot;
        if (rst) begin
            m_t = 0; m_shadow = 16'h0; m_pending = 16'h0; m_ready = 1'b1;
            e.rdy = 1'b1; e.code = 4'h0; e.an = 4'hF; e.fd = 1'b0;
        end else begin
            boundary = (m_t == FRAME - 1);
            accept   = ld && m_ready;
            if (accept) begin
                m_pending = val;
                m_ready   = 1'b0;
            end else if (boundary && !m_ready) begin
                m_shadow = m_pending;
                m_ready  = 1'b1;
            end
            m_t    = (m_t + 1) % FRAME;
            slot   = m_t / RDIV;
            cyc    = m_t % RDIV;
            upper  = m_shadow >> (4 * slot);
            onehot = 4'b0001 << slot;
            e.rdy  = m_ready;
            e.code = upper[3:0];
            e.fd   = boundary;
            if (cyc < GRD || (blz && slot != 0 && upper == 16'h0))
                e.an = 4'hF;
            else
                e.an = ~onehot;
        end
        exp_q.push_back(e);
    endtask

    // Drive one cycle of inputs, predict the post-edge outputs, and advance to the next negedge.
    task automatic step(input bit rst, input bit ld, input logic [15:0] val, input bit blz);
        RST      = rst;
        load     = ld;
        value    = val;
        blank_lz = blz;
        model_step(rst, ld, val, blz);
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic idle(input int n, input bit blz);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 16'h0, blz);
    endtask

    task automatic idle_until(input int t, input bit need_ready, input bit blz);
        for (int k = 0; k < 4 * FRAME && !(m_t == t && (!need_ready || m_ready)); k++)
            step(1'b0, 1'b0, 16'h0, blz);
    endtask

    // Monitor: one scoreboard entry retires per clock edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            cycle_no++;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                vectors++;
                if (ready !== e.rdy || digit_code !== e.code || an !== e.an || frame_done !== e.fd) begin
                    miscompares++;
                    $display("FAIL outputs cycle %0d: got ready=%b code=%h an=%b fd=%b, expected ready=%b code=%h an=%b fd=%b",
                             cycle_no, ready, digit_code, an, frame_done, e.rdy, e.code, e.an, e.fd);
                end
            end
        end
    end

    initial begin
        bit          blz;
        bit          ld;
        bit          rs;
        logic [15:0] v;
        RST = 1'b1; load = 1'b0; value = 16'h0; blank_lz = 1'b0;
        m_t = 0; m_shadow = 16'h0; m_pending = 16'h0; m_ready = 1'b1;

        step(1'b1, 1'b0, 16'h0, 1'b0);
        step(1'b1, 1'b0, 16'h0, 1'b0);
        idle(2 * FRAME + 3, 1'b0);

        // Mid-slot-1 load, then an ignored load while the buffer is busy.
        idle_until(12, 1'b0, 1'b0);
        step(1'b0, 1'b1, 16'h1234, 1'b0);
        idle(5, 1'b0);
        step(1'b0, 1'b1, 16'h9999, 1'b0);
        idle(2 * FRAME, 1'b0);

        // Load on the boundary edge, then watch blanking of 0042 and 0000.
        idle_until(FRAME - 1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 16'h0042, 1'b1);
        idle(3 * FRAME, 1'b1);
        step(1'b0, 1'b1, 16'h0000, 1'b1);
        idle(3 * FRAME, 1'b1);
        idle(FRAME + 4, 1'b0);

        // Reset during slot 2 with a pending value outstanding.
        idle_until(2, 1'b1, 1'b0);
        step(1'b0, 1'b1, 16'h5678, 1'b0);
        idle_until(2 * RDIV + 3, 1'b0, 1'b0);
        step(1'b1, 1'b0, 16'h0, 1'b0);
        idle(2 * FRAME, 1'b0);

        // Randomized traffic including nibbles 10..15 and sporadic resets.
        blz = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 63) == 0) blz = ~blz;
            rs = ($urandom_range(0, 299) == 0);
            ld = ($urandom_range(0, 7) == 0);
            v  = 16'($urandom);
            if ($urandom_range(0, 3) == 0) v = v & 16'h00FF;
            if ($urandom_range(0, 7) == 0) v = 16'h0000;
            step(rs, ld, v, blz);
        end

        for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(negedge CLK);
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d entries left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
